ebi_arbiter: RTL and testbench

Shares one EBI slave bus (active-low `ebi_cs`/`ebi_rden`/`ebi_wren`, 16-bit address and data) between `NUM_REQ` independent requesters, such as the UART-to-EBI bridge and on-chip masters. It grants one requester at a time using round-robin arbitration. It then runs the complete strobe sequence for the granted access, samples read data and returns a single-cycle acknowledge. It sits between the requesters and the EBI pins, and is the only driver of those pins.

---
 rtl/ebi_arb_pkg.sv | 17 +
 rtl/ebi_arbiter_if.sv | 38 +++
 rtl/ebi_rr_picker.sv | 42 ++++
 rtl/ebi_arbiter.sv | 89 ++++++++
 tb/tb_ebi_arbiter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/ebi_arb_pkg.sv
// Shared constants and state encoding for the EBI bus arbiter.
package ebi_arb_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;

  localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
  localparam logic [1:0] ST_ACCESS_ENC = 2'd1;
  localparam logic [1:0] ST_TURN_ENC   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE_ENC,
    S_ACCESS = ST_ACCESS_ENC,
    S_TURN   = ST_TURN_ENC
  } arb_state_e;

endpackage

// File: rtl/ebi_arbiter_if.sv
// Requester handshake plus EBI pin bundle; slave = arbiter view, master = requesters/pins view.
interface ebi_arbiter_if
  import ebi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
);
  localparam int unsigned IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ack;
  logic [DATA_W-1:0]         req_rdata;

  logic                      ebi_cs;
  logic                      ebi_rden;
  logic                      ebi_wren;
  logic [ADDR_W-1:0]         ebi_addr;
  logic [DATA_W-1:0]         ebi_dout;
  logic [DATA_W-1:0]         ebi_din;

  logic                      busy;
  logic [IDW-1:0]            grant_id;

  modport slave (
    input  req, req_we, req_addr, req_wdata, ebi_din,
    output req_ack, req_rdata, ebi_cs, ebi_rden, ebi_wren, ebi_addr, ebi_dout,
           busy, grant_id
  );

  modport master (
    output req, req_we, req_addr, req_wdata, ebi_din,
    input  req_ack, req_rdata, ebi_cs, ebi_rden, ebi_wren, ebi_addr, ebi_dout,
           busy, grant_id
  );

endinterface

// File: rtl/ebi_rr_picker.sv
// Combinational winner selection: round-robin after `last`, or fixed lowest-index
// priority when EBI_ARB_FIXED_PRIO_EN is defined.
module ebi_rr_picker #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last,
  output logic                       valid,
  output logic [$clog2(NUM_REQ)-1:0] winner
);
  localparam int unsigned IDW = $clog2(NUM_REQ);

`ifdef EBI_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last;

  // Descending scan so the lowest set index is the final assignment.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid  = 1'b1;
        winner = IDW'(i);
      end
    end
  end
`else
  // Descending offset scan so the requester closest after `last` wins.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    for (int i = int'(NUM_REQ); i >= 1; i--) begin
      if (req[(int'(last) + i) % int'(NUM_REQ)]) begin
        valid  = 1'b1;
        winner = IDW'((int'(last) + i) % int'(NUM_REQ));
      end
    end
  end
`endif

endmodule

// File: rtl/ebi_arbiter.sv
// Round-robin EBI bus arbiter: grants one requester, runs the strobe sequence,
// returns a one-cycle ack. EBI_ARB_FIXED_PRIO_EN selects fixed priority instead.
module ebi_arbiter
  import ebi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned WR_CYCLES = 1,
  parameter int unsigned RD_CYCLES = 9
) (
  input  logic           clk,
  input  logic           rst,
  ebi_arbiter_if.slave   bus
);
  localparam int unsigned IDW    = $clog2(NUM_REQ);
  localparam int unsigned MAX_CY = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
  localparam int unsigned CW     = $clog2(MAX_CY + 1);

  arb_state_e      state;
  logic [CW-1:0]   cnt;
  logic [IDW-1:0]  last;
  logic            pick_valid_c;
  logic [IDW-1:0]  pick_id_c;

  ebi_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req    (bus.req),
    .last   (last),
    .valid  (pick_valid_c),
    .winner (pick_id_c)
  );

  // Arbitration FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      last          <= IDW'(NUM_REQ - 1);
      bus.ebi_cs    <= 1'b1;
      bus.ebi_rden  <= 1'b1;
      bus.ebi_wren  <= 1'b1;
      bus.ebi_addr  <= '0;
      bus.ebi_dout  <= '0;
      bus.req_rdata <= '0;
      bus.req_ack   <= '0;
      bus.busy      <= 1'b0;
      bus.grant_id  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_valid_c) begin
            bus.ebi_addr <= bus.req_addr[ADDR_W*int'(pick_id_c) +: ADDR_W];
            bus.ebi_dout <= bus.req_wdata[DATA_W*int'(pick_id_c) +: DATA_W];
            bus.ebi_cs   <= 1'b0;
            bus.ebi_wren <= ~bus.req_we[pick_id_c];
            bus.ebi_rden <= bus.req_we[pick_id_c];
            cnt          <= bus.req_we[pick_id_c] ? CW'(WR_CYCLES) : CW'(RD_CYCLES);
            bus.grant_id <= pick_id_c;
            bus.busy     <= 1'b1;
            state        <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (cnt == CW'(1)) begin
            // A low rden marks the access in flight as a read.
            if (!bus.ebi_rden) begin
              bus.req_rdata <= bus.ebi_din;
            end
            bus.ebi_cs   <= 1'b1;
            bus.ebi_rden <= 1'b1;
            bus.ebi_wren <= 1'b1;
            bus.req_ack  <= NUM_REQ'(1) << bus.grant_id;
            last         <= bus.grant_id;
            state        <= S_TURN;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_TURN: begin
          bus.req_ack <= '0;
          bus.busy    <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ebi_arbiter.sv
// Scoreboard bench for ebi_arbiter: expected acks queued at request time, checked on ack.
module tb_ebi_arbiter;
  localparam int unsigned NREQ = 2;
  localparam int WR = 1;
  localparam int RD = 9;

  typedef struct {
    int          id;
    bit          we;
    logic [15:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];

  ebi_arbiter_if #(.NUM_REQ(NREQ)) bus ();

  ebi_arbiter #(
    .NUM_REQ   (NREQ),
    .WR_CYCLES (WR),
    .RD_CYCLES (RD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input bit we, input logic [15:0] addr,
                         input logic [15:0] wd);
    bus.req_we[id]          = we;
    bus.req_addr[16*id +: 16]  = addr;
    bus.req_wdata[16*id +: 16] = wd;
    bus.req[id]             = 1'b1;
  endtask

  task automatic push_exp(input int id, input bit we, input logic [15:0] rd);
    exp_t e;
    e.id = id; e.we = we; e.rdata = rd;
    exp_q.push_back(e);
  endtask

  // Scoreboard consumer: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.req_ack != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 32'(bus.req_ack), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_ack_id", 32'(bus.req_ack), 32'(2'b01 << e.id));
        if (!e.we) check("sb_rdata", 32'(bus.req_rdata), 32'(e.rdata));
      end
    end
  end

  task automatic write_access(input int id, input logic [15:0] addr, input logic [15:0] wd);
    set_req(id, 1'b1, addr, wd);
    push_exp(id, 1'b1, 16'h0);
    tick();
    check("wr_strobes_c1", {bus.ebi_cs, bus.ebi_rden, bus.ebi_wren}, 3'b010);
    check("wr_addr", 32'(bus.ebi_addr), 32'(addr));
    check("wr_dout", 32'(bus.ebi_dout), 32'(wd));
    check("wr_busy", 32'(bus.busy), 32'd1);
    check("wr_grant", 32'(bus.grant_id), 32'(id));
    tick();
    check("wr_ack", 32'(bus.req_ack), 32'(2'b01 << id));
    check("wr_strobes_c2", {bus.ebi_cs, bus.ebi_rden, bus.ebi_wren}, 3'b111);
    bus.req[id] = 1'b0;
    tick();
    check("wr_ack_clear", 32'(bus.req_ack), 32'd0);
    check("wr_busy_clear", 32'(bus.busy), 32'd0);
  endtask

  // Data on ebi_din is correct only in the last strobe cycle to pin the sample edge.
  task automatic read_access(input int id, input logic [15:0] addr, input logic [15:0] din);
    int lows = 0;
    bus.ebi_din = 16'h1111;
    set_req(id, 1'b0, addr, 16'h0);
    push_exp(id, 1'b0, din);
    for (int k = 1; k <= RD; k++) begin
      tick();
      if (k == 1) check("rd_start", 32'(bus.ebi_rden), 32'd0);
      if (!bus.ebi_cs && !bus.ebi_rden && bus.ebi_wren) lows++;
      if (k == RD) bus.ebi_din = din;
    end
    check("rd_low_cycles", 32'(lows), 32'(RD));
    check("rd_addr", 32'(bus.ebi_addr), 32'(addr));
    tick();
    bus.ebi_din = 16'hFFFF;
    check("rd_ack", 32'(bus.req_ack), 32'(2'b01 << id));
    check("rd_data", 32'(bus.req_rdata), 32'(din));
    check("rd_strobes_hi", {bus.ebi_cs, bus.ebi_rden, bus.ebi_wren}, 3'b111);
    bus.req[id] = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.ebi_din = '0;
    tick(); tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_strobes", {bus.ebi_cs, bus.ebi_rden, bus.ebi_wren}, 3'b111);
    check("rst_addr_dout", {bus.ebi_addr, bus.ebi_dout}, 32'd0);
    check("rst_rdata", 32'(bus.req_rdata), 32'd0);
    check("rst_ack_busy_gid", {bus.req_ack, bus.busy, bus.grant_id}, 32'd0);

    write_access(1, 16'h1234, 16'hBEEF);
    tick();
    read_access(0, 16'h0010, 16'h5A5A);
    tick(); tick();

    // Both requesters held: grant order from a bench-side arbitration model
    pulse_reset();
    begin
      int ml = 1;
      int acks = 0;
      int hi_run = 0;
      bit seen_low = 1'b0;
      logic prev_cs = 1'b1;
      for (int n = 0; n < 4; n++) begin
        int w;
`ifdef EBI_ARB_FIXED_PRIO_EN
        w = 0;
`else
        w = (ml + 1) % 2;
`endif
        ml = w;
        push_exp(w, (w == 0), 16'h3C3C);
      end
      bus.ebi_din = 16'h3C3C;
      set_req(0, 1'b1, 16'h0100, 16'h0A0A);
      set_req(1, 1'b0, 16'h0101, 16'h0000);
      for (int c = 0; c < 200 && acks < 4; c++) begin
        tick();
        if (!bus.ebi_cs && prev_cs && seen_low) check("rr_gap", 32'(hi_run), 32'd2);
        if (bus.ebi_cs) hi_run++;
        else begin hi_run = 0; seen_low = 1'b1; end
        prev_cs = bus.ebi_cs;
        if (bus.req_ack != '0) begin
          acks++;
          if (acks == 4) bus.req = '0;
        end
      end
      check("rr_done", 32'(acks), 32'd4);
    end
    tick(); tick();

    // Reset in cycle 4 of a read aborts it without ack
    read_abort: begin
      set_req(0, 1'b0, 16'h0020, 16'h0);
      for (int k = 1; k <= 4; k++) tick();
      rst = 1'b1;
      tick();
      check("abort_strobes", {bus.ebi_cs, bus.ebi_rden, bus.ebi_wren}, 3'b111);
      check("abort_busy_ack", {bus.busy, bus.req_ack}, 32'd0);
      rst = 1'b0;
      bus.req = '0;
      tick(); tick(); tick();
      check("abort_idle_cs", 32'(bus.ebi_cs), 32'd1);
    end
    write_access(1, 16'h0042, 16'h55AA);
    tick();

    // Request dropped during the access; fields changed after latching
    begin
      int lows = 0;
      int extra = 0;
      set_req(0, 1'b1, 16'h0077, 16'hC0DE);
      push_exp(0, 1'b1, 16'h0);
      tick();
      check("drop_strobes_c1", {bus.ebi_cs, bus.ebi_rden, bus.ebi_wren}, 3'b010);
      bus.req[0] = 1'b0;
      bus.req_addr[15:0] = 16'hDEAD;
      tick();
      check("drop_ack", 32'(bus.req_ack), 32'd1);
      check("drop_addr_held", 32'(bus.ebi_addr), 32'h0077);
      for (int k = 0; k < 10; k++) begin
        tick();
        if (!bus.ebi_cs) lows++;
        if (bus.req_ack != '0) extra++;
      end
      check("drop_no_reaccess", 32'(lows + extra), 32'd0);
    end

    // Back-to-back reads: drop after ack, reassert -> next strobe 3 cycles after ack
    read_access(1, 16'h0200, 16'h1357);
    tick();
    check("b2b_gap_c1", 32'(bus.ebi_rden), 32'd1);
    tick();
    check("b2b_gap_c2", 32'(bus.ebi_rden), 32'd1);
    read_access(1, 16'h0202, 16'h2468);
    tick(); tick();

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
